// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-requester data memory arbiter.
// The byte merge is written at a maximum width so every arbiter instance can share it.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    localparam int NUM_REQ        = 2;
    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    // Callers zero-extend narrower words and truncate the result back to their width.
    function automatic logic [MAX_DATA_WIDTH-1:0] mergeBytes(
        input logic [MAX_STRB_WIDTH-1:0] strb,
        input logic [MAX_DATA_WIDTH-1:0] newData,
        input logic [MAX_DATA_WIDTH-1:0] oldData
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = oldData;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = newData[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; the last-grant register lives in the parent.
// last_grant = 1 means requester 1 was granted most recently, so requester 0 wins a tie.
module rr_arbiter2 (
    input  logic valid_0,
    input  logic valid_1,
    input  logic last_grant,
    output logic grant_0,
    output logic grant_1
);

    always_comb begin
        grant_0 = valid_0 && (!valid_1 || last_grant);
        grant_1 = valid_1 && (!valid_0 || !last_grant);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data memory between the load/store unit and the
// debug/loader port; partial writes become a read-modify-write because the memory has no byte enables.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid_0,
    output logic                    req_ready_0,
    input  logic                    req_write_0,
    input  logic [ADDR_WIDTH-1:0]   req_addr_0,
    input  logic [DATA_WIDTH-1:0]   req_wdata_0,
    input  logic [DATA_WIDTH/8-1:0] req_strb_0,
    output logic                    resp_valid_0,
    output logic [DATA_WIDTH-1:0]   resp_data_0,
    input  logic                    req_valid_1,
    output logic                    req_ready_1,
    input  logic                    req_write_1,
    input  logic [ADDR_WIDTH-1:0]   req_addr_1,
    input  logic [DATA_WIDTH-1:0]   req_wdata_1,
    input  logic [DATA_WIDTH/8-1:0] req_strb_1,
    output logic                    resp_valid_1,
    output logic [DATA_WIDTH-1:0]   resp_data_1,
    output logic                    busy,
    output logic                    mem_readEnable,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_writeEnable,
    output logic [DATA_WIDTH-1:0]   mem_writeData,
    input  logic [DATA_WIDTH-1:0]   mem_readData
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state, stateNext;
    logic                    lastGrant;
    logic                    grant0, grant1;
    logic                    accept, selOwner, selWrite;
    logic                    isFull, isPartial;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selWdata;
    logic [STRB_WIDTH-1:0]   selStrb;

    logic                    rmwOwner_p1;
    logic [ADDR_WIDTH-1:0]   rmwAddr_p1;
    logic [DATA_WIDTH-1:0]   rmwWdata_p1;
    logic [STRB_WIDTH-1:0]   rmwStrb_p1;
    logic [DATA_WIDTH-1:0]   merged;

    logic                    rspVld_p1;
    logic                    rspOwner_p1;
    logic                    rspRead_p1;

    rr_arbiter2 arb (
        .valid_0    (req_valid_0),
        .valid_1    (req_valid_1),
        .last_grant (lastGrant),
        .grant_0    (grant0),
        .grant_1    (grant1)
    );

    always_comb begin
        accept    = (state == IDLE) && (grant0 || grant1);
        selOwner  = grant1;
        selWrite  = grant1 ? req_write_1 : req_write_0;
        selAddr   = grant1 ? req_addr_1  : req_addr_0;
        selWdata  = grant1 ? req_wdata_1 : req_wdata_0;
        selStrb   = grant1 ? req_strb_1  : req_strb_0;
        isFull    = &selStrb;
        isPartial = !isFull && (|selStrb);
    end

    always_comb begin
        merged = DATA_WIDTH'(mergeBytes(MAX_STRB_WIDTH'(rmwStrb_p1),
                                        MAX_DATA_WIDTH'(rmwWdata_p1),
                                        MAX_DATA_WIDTH'(mem_readData)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept && selWrite && isPartial) stateNext = RMW;
            RMW:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        req_ready_0     = (state == IDLE) && grant0;
        req_ready_1     = (state == IDLE) && grant1;
        busy            = (state == RMW);
        mem_readEnable  = 1'b0;
        mem_writeEnable = 1'b0;
        mem_address     = '0;
        mem_writeData   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!selWrite || isPartial) begin
                        mem_readEnable = 1'b1;
                        mem_address    = selAddr;
                    end else if (isFull) begin
                        mem_writeEnable = 1'b1;
                        mem_address     = selAddr;
                        mem_writeData   = selWdata;
                    end
                end
            end
            RMW: begin
                // A reset landing on the merge cycle drops the write.
                mem_writeEnable = !reset;
                mem_address     = rmwAddr_p1;
                mem_writeData   = merged;
            end
            default: ;
        endcase
    end

    // ---- stage p1: response and read-modify-write context ----
    always_ff @(posedge clock) begin
        if (reset) begin
            rspVld_p1 <= 1'b0;
            lastGrant <= 1'b1;
        end else begin
            rspVld_p1 <= (accept && !(selWrite && isPartial)) || (state == RMW);
            if (accept) lastGrant <= selOwner;
        end
    end

    always_ff @(posedge clock) begin
        rspOwner_p1 <= (state == RMW) ? rmwOwner_p1 : selOwner;
        rspRead_p1  <= (state == IDLE) && !selWrite;
        if (accept) begin
            rmwOwner_p1 <= selOwner;
            rmwAddr_p1  <= selAddr;
            rmwWdata_p1 <= selWdata;
            rmwStrb_p1  <= selStrb;
        end
    end

    always_comb begin
        resp_valid_0 = rspVld_p1 && !rspOwner_p1;
        resp_valid_1 = rspVld_p1 && rspOwner_p1;
        resp_data_0  = (resp_valid_0 && rspRead_p1) ? mem_readData : '0;
        resp_data_1  = (resp_valid_1 && rspRead_p1) ? mem_readData : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory plus a transaction-level reference model
// that predicts grants, memory traffic and responses every cycle.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        v0, v1, w0, w1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  s0, s1;
    logic        r0, r1, rv0, rv1, busy;
    logic [31:0] rd0, rd1;
    logic        mRe, mWe;
    logic [9:0]  mA;
    logic [31:0] mWd, mRd;

    logic        plWe;
    logic [9:0]  plA;
    logic [31:0] plD;
    logic [31:0] memArr [0:1023];

    logic [31:0] refMem [0:1023];
    logic        mBusy, mLast;
    logic        sV [2];
    logic        sO [2];
    logic [31:0] sD [2];
    logic        rO;
    logic [9:0]  rA;
    logic [31:0] rD;
    logic [3:0]  rS;
    logic        acc0, acc1;
    int          weCount;
    int          nChecks, nErrors;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid_0     (v0),
        .req_ready_0     (r0),
        .req_write_0     (w0),
        .req_addr_0      (a0),
        .req_wdata_0     (d0),
        .req_strb_0      (s0),
        .resp_valid_0    (rv0),
        .resp_data_0     (rd0),
        .req_valid_1     (v1),
        .req_ready_1     (r1),
        .req_write_1     (w1),
        .req_addr_1      (a1),
        .req_wdata_1     (d1),
        .req_strb_1      (s1),
        .resp_valid_1    (rv1),
        .resp_data_1     (rd1),
        .busy            (busy),
        .mem_readEnable  (mRe),
        .mem_address     (mA),
        .mem_writeEnable (mWe),
        .mem_writeData   (mWd),
        .mem_readData    (mRd)
    );

    always @(posedge clock) begin
        if (plWe) memArr[plA] <= plD;
        else if (mWe) memArr[mA] <= mWd;
        mRd <= mRe ? memArr[mA] : 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mergeModel(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
        return (newW & mask) | (oldW & ~mask);
    endfunction

    task automatic runChecker();
        logic g0, g1, o, w, eRe, eWe, e0v, e1v, nBusy;
        logic [9:0]  a, eA;
        logic [31:0] d, eWd, e0d, e1d, mg;
        logic [3:0]  s;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (plWe) refMem[plA] = plD;
                if (mBusy) check("rstNoWe", 32'(mWe), 32'd0);
                mBusy = 1'b0; mLast = 1'b1;
                sV[0] = 1'b0; sV[1] = 1'b0;
                acc0 = 1'b0; acc1 = 1'b0;
            end else begin
                if (mWe) weCount++;
                check("busy", 32'(busy), 32'(mBusy));
                e0v = sV[0] && !sO[0];
                e1v = sV[0] && sO[0];
                e0d = e0v ? sD[0] : 32'd0;
                e1d = e1v ? sD[0] : 32'd0;
                check("respV0", 32'(rv0), 32'(e0v));
                check("respV1", 32'(rv1), 32'(e1v));
                check("respD0", rd0, e0d);
                check("respD1", rd1, e1d);
                sV[0] = sV[1]; sO[0] = sO[1]; sD[0] = sD[1]; sV[1] = 1'b0;
                eRe = 1'b0; eWe = 1'b0; eA = 10'd0; eWd = 32'd0; nBusy = 1'b0;
                if (mBusy) begin
                    mg = mergeModel(refMem[rA], rD, rS);
                    refMem[rA] = mg;
                    eWe = 1'b1; eA = rA; eWd = mg;
                    sV[0] = 1'b1; sO[0] = rO; sD[0] = 32'd0;
                end
                g0 = 1'b0; g1 = 1'b0;
                if (!mBusy) begin
                    if (v0 && v1) begin g0 = mLast; g1 = !mLast; end
                    else begin g0 = v0; g1 = v1; end
                end
                check("ready0", 32'(r0), 32'(g0));
                check("ready1", 32'(r1), 32'(g1));
                if (g0 || g1) begin
                    o = g1;
                    w = g1 ? w1 : w0;
                    a = g1 ? a1 : a0;
                    d = g1 ? d1 : d0;
                    s = g1 ? s1 : s0;
                    mLast = o;
                    if (!w) begin
                        eRe = 1'b1; eA = a;
                        sV[0] = 1'b1; sO[0] = o; sD[0] = refMem[a];
                    end else if (s == 4'hF) begin
                        eWe = 1'b1; eA = a; eWd = d; refMem[a] = d;
                        sV[0] = 1'b1; sO[0] = o; sD[0] = 32'd0;
                    end else if (s == 4'h0) begin
                        sV[0] = 1'b1; sO[0] = o; sD[0] = 32'd0;
                    end else begin
                        eRe = 1'b1; eA = a; nBusy = 1'b1;
                        rO = o; rA = a; rD = d; rS = s;
                    end
                end
                mBusy = nBusy;
                check("memRe", 32'(mRe), 32'(eRe));
                check("memWe", 32'(mWe), 32'(eWe));
                check("memAddr", 32'(mA), 32'(eA));
                check("memWd", mWd, eWd);
                acc0 = v0 && r0;
                acc1 = v1 && r1;
            end
        end
    endtask

    task automatic setReq(input int r, input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        if (r == 0) begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; s0 = s; end
        else        begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; s1 = s; end
    endtask

    task automatic stepIdle(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(posedge clock); #1;
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            if (!v0 && !v1) return;
        end
        check("timeout", 32'(v0 || v1), 32'd0);
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic randReq(output logic w, output logic [9:0] a, output logic [31:0] d,
                           output logic [3:0] s);
        int unsigned kind;
        kind = $urandom_range(0, 3);
        w = (kind != 0);
        a = 10'h100 + 10'($urandom_range(0, 15));
        d = $urandom;
        s = (kind == 1) ? 4'hF : (kind == 2) ? 4'h0 : 4'($urandom_range(1, 14));
    endtask

    task automatic stimulus();
        int  wb;
        logic prev;
        reset = 1'b1; plWe = 1'b0; plA = '0; plD = '0;
        v0 = 0; v1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;
        @(posedge clock); #1;
        for (int i = 0; i < 1024; i++) begin
            plWe = 1'b1; plA = 10'(i);
            case (i)
                5:       plD = 32'hDEADBEEF;
                32:      plD = 32'h11223344;
                48:      plD = 32'h0BADF00D;
                64:      plD = 32'h55667788;
                default: plD = $urandom;
            endcase
            @(posedge clock); #1;
        end
        plWe = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;

        setReq(0, 1'b0, 10'h005, 32'd0, 4'h0);
        stepIdle(20);

        setReq(0, 1'b0, 10'h001, 32'd0, 4'h0);
        setReq(1, 1'b0, 10'h002, 32'd0, 4'h0);
        prev = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            check("altOne", 32'(acc0 ^ acc1), 32'd1);
            if (c > 0) check("altSwap", 32'(acc0), 32'(!prev));
            prev = acc0;
        end
        if (acc0) v0 = 1'b0;
        if (acc1) v1 = 1'b0;
        stepIdle(20);

        setReq(1, 1'b1, 10'h010, 32'hCAFEF00D, 4'hF);
        stepIdle(20);
        setReq(0, 1'b0, 10'h010, 32'd0, 4'h0);
        stepIdle(20);

        setReq(0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101);
        stepIdle(20);
        setReq(0, 1'b0, 10'h020, 32'd0, 4'h0);
        stepIdle(20);

        wb = weCount;
        setReq(0, 1'b1, 10'h030, 32'h12345678, 4'h0);
        stepIdle(20);
        check("zsWe", 32'(weCount - wb), 32'd0);
        setReq(1, 1'b0, 10'h030, 32'd0, 4'h0);
        stepIdle(20);

        setReq(0, 1'b1, 10'h040, 32'hFFFFFFFF, 4'b0011);
        @(posedge clock); #1;
        check("rstAcc", 32'(acc0), 32'd1);
        v0 = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        setReq(0, 1'b0, 10'h040, 32'd0, 4'h0);
        setReq(1, 1'b0, 10'h041, 32'd0, 4'h0);
        @(posedge clock); #1;
        check("tieFirst", 32'(acc0), 32'd1);
        if (acc0) v0 = 1'b0;
        if (acc1) v1 = 1'b0;
        stepIdle(20);
        repeat (3) @(posedge clock);
        #1;
        check("mem010", memArr[10'h010], 32'hCAFEF00D);
        check("mem020", memArr[10'h020], 32'h11BB33DD);
        check("mem030", memArr[10'h030], 32'h0BADF00D);
        check("mem040", memArr[10'h040], 32'h55667788);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            if (!v0 && $urandom_range(0, 99) < 70) begin
                randReq(w0, a0, d0, s0);
                v0 = 1'b1;
            end
            if (!v1 && $urandom_range(0, 99) < 70) begin
                randReq(w1, a1, d1, s1);
                v1 = 1'b1;
            end
        end
        stepIdle(20);
        repeat (4) @(posedge clock);
        #1;
        for (int i = 256; i < 272; i++) check("memFinal", memArr[i], refMem[i]);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    endtask

    initial begin
        nChecks = 0; nErrors = 0; weCount = 0;
        mBusy = 1'b0; mLast = 1'b1;
        sV[0] = 1'b0; sV[1] = 1'b0; sO[0] = 1'b0; sO[1] = 1'b0; sD[0] = '0; sD[1] = '0;
        rO = 1'b0; rA = '0; rD = '0; rS = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        fork
            runChecker();
            stimulus();
        join
    end

endmodule
